// File: rtl/param_scroll_window.sv
// param_scroll_window
// Text-scrolling engine: holds up to NUM_CHARS packed ASCII characters and
// presents a WIN_DIGITS-character window that advances once per dwell period.
// Modes: 0 = static, 1 = single pass, 2/3 = continuous wrap with a blank gap
// of WIN_DIGITS characters between repetitions.
//
// Build option: define SCROLL_LEADIN_EN to start scrolling from a blank
// window so the text enters from the right-hand digit.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   text_in      packed ASCII, char 0 in the most-significant byte
//   text_len     valid characters (clamped to NUM_CHARS)
//   mode         scroll mode, sampled on the load handshake
//   load_valid   load request
//   load_ready   engine accepts a load (low only while scrolling)
//   pause        freezes dwell counter and position
//   stop         abort and return to idle
//   win_ascii    visible window, leftmost digit in the MSB byte
//   pos          current scroll position
//   step         one-cycle pulse when the window advances
//   busy         high while scrolling
//   scroll_done  one-cycle pulse at the end of a single pass
module param_scroll_window #(
   parameter int NUM_CHARS    = 16,
   parameter int WIN_DIGITS   = 4,
   parameter int LEN_BITS     = 5,
   parameter int DWELL_CYCLES = 50_000_000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CHARS*8-1:0]    text_in,
   input  logic [LEN_BITS-1:0]       text_len,
   input  logic [1:0]                mode,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic                      pause,
   input  logic                      stop,
   output logic [WIN_DIGITS*8-1:0]   win_ascii,
   output logic [LEN_BITS-1:0]       pos,
   output logic                      step,
   output logic                      busy,
   output logic                      scroll_done
);

   localparam int CNT_W = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef SCROLL_LEADIN_EN
   localparam int OFFSET = WIN_DIGITS;
`else
   localparam int OFFSET = 0;
`endif
   localparam logic [LEN_BITS-1:0] NUM_CHARS_L = LEN_BITS'(NUM_CHARS);
   localparam logic [LEN_BITS-1:0] WIN_L       = LEN_BITS'(WIN_DIGITS);
   localparam logic [LEN_BITS-1:0] OFFSET_L    = LEN_BITS'(OFFSET);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHOW   = 2'd1,
      ST_SCROLL = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                   state_r, state_s;
   logic [NUM_CHARS*8-1:0]   text_r, text_s;
   logic [LEN_BITS-1:0]      len_r, len_s, load_len_s, pos_inc_s;
   logic [1:0]               mode_r, mode_s;
   logic [LEN_BITS-1:0]      pos_r, pos_s;
   logic [CNT_W-1:0]         cnt_r, cnt_s;
   logic [WIN_DIGITS*8-1:0]  win_r, win_s;
   logic                     step_r, step_s;
   logic                     done_r, done_s;
   logic                     busy_r, ready_r;
   int                       virt_s;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and datapath update; priority stop > load > dwell step
   always_comb begin
      state_s    = state_r;
      text_s     = text_r;
      len_s      = len_r;
      mode_s     = mode_r;
      pos_s      = pos_r;
      cnt_s      = cnt_r;
      step_s     = 1'b0;
      done_s     = 1'b0;
      pos_inc_s  = pos_r + LEN_BITS'(1);
      load_len_s = (text_len > NUM_CHARS_L) ? NUM_CHARS_L : text_len;

      if (stop) begin
         // A zero length blanks the window without touching the text store
         state_s = ST_IDLE;
         len_s   = LEN_BITS'(0);
         pos_s   = LEN_BITS'(0);
         cnt_s   = CNT_W'(0);
      end else if (load_valid && ready_r) begin
         text_s = text_in;
         len_s  = load_len_s;
         mode_s = mode;
         pos_s  = LEN_BITS'(0);
         cnt_s  = CNT_W'(0);
         if ((mode == 2'd0) || (load_len_s == LEN_BITS'(0)) ||
             ((OFFSET == 0) && (load_len_s <= WIN_L))) begin
            state_s = ST_SHOW;
         end else begin
            state_s = ST_SCROLL;
         end
      end else if ((state_r == ST_SCROLL) && !pause) begin
         if (cnt_r == CNT_LAST) begin
            cnt_s  = CNT_W'(0);
            step_s = 1'b1;
            if (mode_r == 2'd1) begin
               pos_s = pos_inc_s;
               // Final position leaves the last char in the rightmost digit
               if (pos_inc_s == (len_r + OFFSET_L - WIN_L)) begin
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s = ST_SCROLL;
               end
            end else begin
               // Wrap period is the text plus one window of blanks
               if (pos_inc_s == (len_r + WIN_L)) begin
                  pos_s = LEN_BITS'(0);
               end else begin
                  pos_s = pos_inc_s;
               end
            end
         end else begin
            cnt_s = cnt_r + CNT_W'(1);
         end
      end else if (state_r != ST_SCROLL) begin
         cnt_s = CNT_W'(0);
      end else begin
         cnt_s = cnt_r;
      end
   end

   // Window content for the next cycle: digit k shows virtual index pos+k-OFFSET
   always_comb begin
      win_s  = {WIN_DIGITS{8'h20}};
      virt_s = 0;
      for (int k = 0; k < WIN_DIGITS; k++) begin
         virt_s = int'(pos_s) + k - OFFSET;
         if ((virt_s >= 0) && (virt_s < int'(len_s))) begin
            win_s[(WIN_DIGITS-1-k)*8 +: 8] = text_s[(NUM_CHARS-1-virt_s)*8 +: 8];
         end else begin
            win_s[(WIN_DIGITS-1-k)*8 +: 8] = 8'h20;
         end
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         text_r  <= {NUM_CHARS{8'h20}};
         len_r   <= LEN_BITS'(0);
         mode_r  <= 2'd0;
         pos_r   <= LEN_BITS'(0);
         cnt_r   <= CNT_W'(0);
         win_r   <= {WIN_DIGITS{8'h20}};
         step_r  <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         text_r  <= text_s;
         len_r   <= len_s;
         mode_r  <= mode_s;
         pos_r   <= pos_s;
         cnt_r   <= cnt_s;
         win_r   <= win_s;
         step_r  <= step_s;
         done_r  <= done_s;
         busy_r  <= (state_s == ST_SCROLL);
         ready_r <= (state_s != ST_SCROLL);
      end
   end

   assign win_ascii   = win_r;
   assign pos         = pos_r;
   assign step        = step_r;
   assign busy        = busy_r;
   assign scroll_done = done_r;
   assign load_ready  = ready_r;

endmodule

// File: doc/param_scroll_window.md
# param_scroll_window

Parametrised text-scrolling engine that stores up to NUM_CHARS packed ASCII characters and presents a WIN_DIGITS-character window that advances once per dwell period. It supports static, single-pass and continuous-wrap modes, and uses a valid/ready load handshake with pause and stop controls. It sits between the text/number formatting logic (binary2bcd, bcd_to_ascii) and the packed-ASCII 7-segment display driver, which consumes `win_ascii` directly.

## Interface
- NUM_CHARS, 16: text buffer depth in characters (≥ WIN_DIGITS).
- WIN_DIGITS, 4: visible window width in characters.
- LEN_BITS, 5: width of length/position fields; must hold NUM_CHARS + WIN_DIGITS.
- DWELL_CYCLES, 50_000_000: clk cycles per scroll step (0.5 s at 100 MHz); ≥ 2.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- text_in  in  NUM_CHARS*8  packed ASCII; char 0 in the most-significant byte.
- text_len  in  LEN_BITS  number of valid chars; values > NUM_CHARS are clamped to NUM_CHARS.
- mode  in  2  0 = static, 1 = single pass, 2 = continuous wrap, 3 = treated as 2.
- load_valid  in  1  load request; text_in, text_len and mode are sampled on handshake.
- load_ready  out  1  engine can accept a load.
- pause  in  1  freezes the dwell counter and position while high.
- stop  in  1  aborts the current text and returns to IDLE.
- win_ascii  out  WIN_DIGITS*8  displayed window; leftmost digit in the MSB byte.
- pos  out  LEN_BITS  current scroll position.
- step  out  1  one-cycle pulse when the window advances.
- busy  out  1  high in SCROLL.
- scroll_done  out  1  one-cycle pulse at the end of a single pass.

## Operation
- States:
  - IDLE: window all 0x20; load_ready = 1.
  - SHOW: static text; load_ready = 1.
  - SCROLL: window advancing; load_ready = 0.
  - DONE: final window held; load_ready = 1.
- Load: a handshake (load_valid & load_ready) copies text, L = min(text_len, NUM_CHARS) and mode, clears pos and the dwell counter, and selects the next state:
  - mode 0 → SHOW.
  - L ≤ WIN_DIGITS (without leadin), or L == 0 → SHOW.
  - Otherwise → SCROLL.
- Window content: digit k shows virtual index v = pos + k − O, where O = WIN_DIGITS when SCROLL_LEADIN_EN is defined and 0 otherwise. A char is shown for 0 ≤ v < L; all other positions show 0x20.
- Single pass (mode 1):
  - pos increments on each step until pos == L − WIN_DIGITS + O.
  - That step also pulses scroll_done and moves to DONE.
- Wrap (mode 2):
  - pos counts modulo P = L + WIN_DIGITS, giving one blank gap of WIN_DIGITS between repetitions.
  - Never reaches DONE; no scroll_done.
- Dwell counter:
  - Counts 0..DWELL_CYCLES−1 in SCROLL while pause = 0.
  - On the terminal count it advances pos, pulses step, and wraps to 0.
  - Holds its value while pause = 1; SHOW, DONE and IDLE hold it at 0.
- stop has priority over load and step. From any state: → IDLE next cycle, pos = 0, window blank, no step or scroll_done.
- Priority order: reset > stop > load > step.

## Timing
- Reset values: state IDLE, win_ascii all 0x20, pos 0, step 0, busy 0, scroll_done 0, load_ready 1, dwell counter 0.
- All outputs are registered.
- win_ascii reflects a new load on the cycle after the handshake edge.
- First step: DWELL_CYCLES cycles after the load edge. Subsequent steps: every DWELL_CYCLES cycles of unpaused SCROLL.
- step, scroll_done and the updated pos/win_ascii all appear in the same cycle.
- busy falls and load_ready rises in the same cycle as scroll_done.
- Pause asserted on a terminal-count cycle suppresses that step; the step fires on the first unpaused cycle thereafter.
- Reset or stop mid-scroll: no partial step; the next cycle matches the IDLE reset state except where a load is accepted.

## Configuration
- SCROLL_LEADIN_EN:
  - Defined: O = WIN_DIGITS. Scrolling starts from a blank window and text enters from the right digit. Single pass ends with the last char in the rightmost digit (final pos = L). A text with 1 ≤ L ≤ WIN_DIGITS in mode 1 or 2 still scrolls.
  - Undefined: O = 0. The first window shows chars 0..WIN_DIGITS−1, and L ≤ WIN_DIGITS goes to SHOW.

## Test plan
- Reset → win_ascii = 0x20202020, load_ready = 1, busy = 0, pos = 0; no pulses for 100 cycles.
- DWELL_CYCLES = 4, no leadin, load "HELLO-JFH " (L = 10), mode 1:
  - Window "HELL" at load + 1, then "ELLO" at load + 4, and so on.
  - Sixth step shows "JFH " with scroll_done = 1, state DONE, pos = 6.
- Same text, mode 2:
  - After step 10, window "    ".
  - Step 14 returns to pos 0 ("HELL"); scroll_done never pulses.
- L = 3 "ABC", mode 1, no leadin → SHOW with window "ABC ", no step for 50 cycles, load_ready = 1.
- Mode 1 scrolling:
  - pause high for 10 cycles spanning a terminal count → that step is delayed exactly 10 cycles.
  - stop mid-scroll → IDLE next cycle, blank window, pos = 0.
- SCROLL_LEADIN_EN, WIN_DIGITS = 4, "AB" mode 1:
  - Windows are "    ", "   A", "  AB".
  - scroll_done fires with the "  AB" step (pos = 2).
